// File: rtl/config_frame_pkg.sv
// Shared types, header layout and header validation for the configuration
// frame writer.
package config_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_e;

    localparam logic [7:0] HDR_MAGIC = 8'hFA;

    // Header word layout: {magic, col, start frame, count}
    localparam int HDR_MAGIC_LSB = 24;
    localparam int HDR_COL_LSB   = 16;
    localparam int HDR_START_LSB = 8;
    localparam int HDR_COUNT_LSB = 0;
    localparam int HDR_FIELD_W   = 8;

    // A header is usable only if it names an existing column and the whole
    // burst fits inside that column. The start+count sum is 9 bits so it
    // cannot wrap back into range.
    function automatic logic hdr_ok(input logic [31:0] w,
                                    input int        num_cols,
                                    input int        frames_per_col);
        logic [8:0] sum;
        sum = {1'b0, w[HDR_START_LSB +: HDR_FIELD_W]}
            + {1'b0, w[HDR_COUNT_LSB +: HDR_FIELD_W]};
        return (w[HDR_MAGIC_LSB +: HDR_FIELD_W] == HDR_MAGIC)
            && (int'(w[HDR_COL_LSB +: HDR_FIELD_W]) < num_cols)
            && (w[HDR_COUNT_LSB +: HDR_FIELD_W] != 8'd0)
            && (int'(sum) <= frames_per_col);
    endfunction

endpackage

// File: rtl/config_frame_writer_strobe_decode.sv
// Registered one-hot FrameStrobe decoder. The register clears
// asynchronously so a reset drops any live latch enable immediately.
module frame_strobe_decode #(
    parameter int NUM_COLUMNS    = 16,
    parameter int FRAMES_PER_COL = 20
) (
    input  logic                                   CLK,
    input  logic                                   resetn,
    input  logic [7:0]                             col,
    input  logic [7:0]                             frame,
    input  logic                                   en,
    output logic [NUM_COLUMNS*FRAMES_PER_COL-1:0]  FrameStrobe
);

    localparam int NBITS = NUM_COLUMNS * FRAMES_PER_COL;

    logic [NBITS-1:0] strobe_d;
    logic [NBITS-1:0] strobe_q;
    int               idx;

    // Decode col/frame to a single enable bit; all zero when not enabled.
    always_comb begin
        idx      = int'(col) * FRAMES_PER_COL + int'(frame);
        strobe_d = '0;
        for (int i = 0; i < NBITS; i++) begin
            strobe_d[i] = en && (idx == i);
        end
    end

    // Strobe register with asynchronous clear.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) strobe_q <= '0;
        else         strobe_q <= strobe_d;
    end

    assign FrameStrobe = strobe_q;

endmodule

// File: rtl/config_frame_writer.sv
// Configuration frame writer: takes a header plus N frame words and writes
// each word into the latch-based config memory with setup and hold around
// a one-hot latch-enable strobe.
module config_frame_writer
    import config_frame_pkg::*;
#(
    parameter int FRAME_BITS     = 32,
    parameter int NUM_COLUMNS    = 16,
    parameter int FRAMES_PER_COL = 20,
    parameter int STROBE_CYCLES  = 1
) (
    input  logic                                   CLK,
    input  logic                                   resetn,
    input  logic [31:0]                            s_data,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    output logic [FRAME_BITS-1:0]                  FrameData,
    output logic [NUM_COLUMNS*FRAMES_PER_COL-1:0]  FrameStrobe,
    output logic                                   busy,
    output logic                                   err,
    input  logic                                   err_clr,
    output logic [15:0]                            frames_done
);

    localparam logic [3:0] STB_LAST = 4'(STROBE_CYCLES - 1);

    state_e                state_q, state_d;
    logic [7:0]            col_q, col_d;
    logic [7:0]            frame_q, frame_d;
    logic [7:0]            remain_q, remain_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] fdata_q, fdata_d;
    logic [15:0]           done_q, done_d;
    logic                  err_q, err_d;
    logic                  rdy_q, rdy_d;
    logic                  err_set;
    logic                  xfer;
    logic                  hdr_good;
    logic                  strobe_en;

    assign xfer     = s_valid && rdy_q;
    assign hdr_good = hdr_ok(s_data, NUM_COLUMNS, FRAMES_PER_COL);

    // Sequencer: IDLE -> LOAD -> SETUP -> STROBE (xN cycles) -> HOLD -> ...
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        frame_d  = frame_q;
        remain_d = remain_q;
        cnt_d    = cnt_q;
        fdata_d  = fdata_q;
        done_d   = done_q;
        err_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (hdr_good) begin
                        col_d    = s_data[HDR_COL_LSB   +: HDR_FIELD_W];
                        frame_d  = s_data[HDR_START_LSB +: HDR_FIELD_W];
                        remain_d = s_data[HDR_COUNT_LSB +: HDR_FIELD_W];
                        state_d  = ST_LOAD;
                    end else begin
                        err_set  = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    fdata_d = s_data[FRAME_BITS-1:0];
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = 4'd0;
                done_d  = done_q + 16'd1;
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt_q == STB_LAST) state_d = ST_HOLD;
                else                   cnt_d   = cnt_q + 4'd1;
            end
            ST_HOLD: begin
                remain_d = remain_q - 8'd1;
                if (remain_q == 8'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    frame_d = frame_q + 8'd1;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A new error outranks a clear in the same cycle.
        err_d     = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
        rdy_d     = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        strobe_en = (state_d == ST_STROBE);
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            frame_q  <= '0;
            remain_q <= '0;
            cnt_q    <= '0;
            fdata_q  <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            frame_q  <= frame_d;
            remain_q <= remain_d;
            cnt_q    <= cnt_d;
            fdata_q  <= fdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdy_q    <= rdy_d;
        end
    end

    // Strobe register is fed from next state so it is high exactly while
    // the sequencer sits in STROBE.
    frame_strobe_decode #(
        .NUM_COLUMNS    (NUM_COLUMNS),
        .FRAMES_PER_COL (FRAMES_PER_COL)
    ) u_decode (
        .CLK         (CLK),
        .resetn      (resetn),
        .col         (col_q),
        .frame       (frame_q),
        .en          (strobe_en),
        .FrameStrobe (FrameStrobe)
    );

    assign s_ready     = rdy_q;
    assign FrameData   = fdata_q;
    assign busy        = (state_q != ST_IDLE);
    assign err         = err_q;
    assign frames_done = done_q;

endmodule
